ppi_rx: RTL and testbench
=========================

Name: ppi_rx

Overview:
- Receive side of the 16-bit PPI link; captures frames from a PPI transmitter running on the same clock domain.
- `ppi_FS` marks word 0 of each frame.
- Words are framed, buffered in a small FIFO and presented on a valid/ready stream with start/end-of-frame flags.
- Framing and overflow errors are flagged for the downstream DSP interface logic.

Parameters:
- FRAME_LEN, 16, words per frame (2..256); word 0 is the one sampled with `ppi_FS`=1.
- DEPTH, 32, FIFO depth in words; power of 2, 4..256.

Ports:
- clk  in  1  system clock; all logic on posedge; `ppi_*` inputs are launched on the same `clk`.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable; 0 = no new frame starts, and words in a frame in progress are discarded.
- ppi_FS  in  1  frame sync, high for exactly the word-0 cycle.
- ppi_data  in  16  PPI data word, one per clk while a frame is active.
- rx_data  out  16  head-of-FIFO word.
- rx_valid  out  1  `rx_data`/`rx_sof`/`rx_eof` valid.
- rx_ready  in  1  consumer accepts the word when `rx_valid` and `rx_ready` are both high.
- rx_sof  out  1  head word is word 0 of a frame.
- rx_eof  out  1  head word is word FRAME_LEN-1.
- frame_err  out  1  one-cycle pulse: `ppi_FS` arrived before the current frame completed.
- overflow  out  1  one-cycle pulse: a captured word was dropped because the FIFO was full.
- ovf_cnt  out  8  saturating count of dropped words.
- busy  out  1  high while in RECV.

Behaviour:
- Reset values:
  - `rx_valid`, `rx_sof`, `rx_eof`, `frame_err`, `overflow`, `busy` = 0.
  - `rx_data` = 0, `ovf_cnt` = 0.
  - FIFO empty, state IDLE, word counter 0.
- Input stage: `ppi_FS` and `ppi_data` are registered at every posedge (stage S1). All framing decisions use the S1 copies.
- State machine (evaluated on S1 values):
  - IDLE:
    - FS=1 and en=1 -> capture word as idx 0 with sof=1, counter=1, go to RECV.
    - FS=0 -> word ignored.
  - RECV:
    - Each cycle, capture the word as idx=counter and increment counter.
    - The word with idx FRAME_LEN-1 is written with eof=1, then return to IDLE.
    - FS=1 while in RECV (counter < FRAME_LEN): pulse `frame_err`; the truncated frame ends without eof; the current word is captured as idx 0 of a new frame (sof=1), counter=1, stay in RECV.
    - en=0 while in RECV: discard the word, go to IDLE, no error.
  - FRAME_LEN=1 is not supported; sof and eof are never set on the same word.
- Back-to-back frames: an FS arriving the cycle after an eof word is normal. The FSM is already in IDLE and starts the new frame with no gap and no error.
- FIFO:
  - Each entry is 18 bits: data, sof, eof. It is first-word-fall-through.
  - Write happens at the edge after S1 capture. A word sampled on `ppi_data` at edge E0 raises `rx_valid` after edge E0+2 when the FIFO was empty.
  - Pop on `rx_valid` & `rx_ready`. The next entry is presented the following cycle; with `rx_ready` held high, one word per cycle is sustained.
  - Full with no pop in the same cycle: the write is dropped, `overflow` pulses, and `ovf_cnt` increments, saturating at 255.
  - Full with a pop in the same cycle: the write is accepted and occupancy is unchanged.
  - Empty: `rx_valid`=0; `rx_sof`/`rx_eof` are forced 0; `rx_data` holds its last value.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-range counter, so full and empty are distinct.
- `frame_err` and `overflow` can pulse in the same cycle.
- A word dropped for overflow still advances the frame counter.
- rst mid-frame:
  - The next edge clears FSM, FIFO contents, pointers, flags and `ovf_cnt`.
  - Words of the interrupted frame are lost.
  - After release, capture resumes only at the next FS.

Test Plan:
- Single frame, FRAME_LEN=16, `rx_ready`=1:
  - Stimulus: FS with data 0x1000, then 0x1001..0x100F on consecutive cycles.
  - Response: 16 words out in order; the first 0x1000 appears 2 edges after its sample with `rx_sof`=1; 0x100F has `rx_eof`=1; `frame_err`=0.
- Continuous transmitter stream:
  - Stimulus: FS every 16 cycles, data = cycle count.
  - Response: 4 frames delivered gap-free, sof/eof on every 16th word, no errors.
- Short frame:
  - Stimulus: FS, 5 words 0xA0..0xA4, then FS with 0xB0.
  - Response: `frame_err` is a 1-cycle pulse; 0xA0..0xA4 are delivered with no eof; 0xB0 has sof=1.
- Backpressure and overflow, DEPTH=32:
  - Stimulus: `rx_ready`=0 for 3 full frames.
  - Response: the first 32 words are stored; 16 `overflow` pulses; `ovf_cnt`=16; releasing `rx_ready` yields exactly 32 words in order.
- Full plus simultaneous pop:
  - Stimulus: fill to 32, then `rx_ready`=1 while a new word arrives.
  - Response: no `overflow`; occupancy stays 32.
- Reset and enable:
  - Stimulus: assert rst at word 7 of a frame.
  - Response: `rx_valid`=0 next cycle; the following non-FS words are ignored; the next FS frame is received intact.
  - Stimulus: en=0 at word 3.
  - Response: the frame is truncated, no error, `busy`=0.

Source files
------------

// File: rtl/ppi_rx.sv
// PPI link receiver: registers the PPI inputs, frames words with sof/eof,
// and buffers them in a first-word-fall-through FIFO behind a valid/ready port.
module ppi_rx #(
    parameter int FRAME_LEN = 16,
    parameter int DEPTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ppi_FS,
    input  logic [15:0] ppi_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        frame_err,
    output logic        overflow,
    output logic [7:0]  ovf_cnt,
    output logic        busy
);

    localparam int DATA_W  = 16;
    localparam int ENTRY_W = DATA_W + 2;
    localparam int AW      = $clog2(DEPTH);
    localparam int OW      = $clog2(DEPTH + 1);
    localparam int CW      = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RECV} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p1: registered copies of the PPI inputs
    logic              fs_p1;
    logic              en_p1;
    logic [DATA_W-1:0] data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_p1 <= 1'b0;
            en_p1 <= 1'b0;
        end else begin
            fs_p1 <= ppi_FS;
            en_p1 <= en;
        end
    end

    always_ff @(posedge clk) begin
        data_p1 <= ppi_data;
    end

    // Framing FSM working on the p1 copies
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_p1, sof_p1, eof_p1, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_p1  = 1'b0;
        sof_p1  = 1'b0;
        eof_p1  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_p1 && fs_p1) begin
                    vld_p1  = 1'b1;
                    sof_p1  = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                // Disable wins over a colliding FS: the frame just stops quietly
                if (!en_p1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (fs_p1) begin
                    ferr_d = 1'b1;
                    vld_p1 = 1'b1;
                    sof_p1 = 1'b1;
                    cnt_d  = CW'(1);
                end else begin
                    vld_p1 = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        eof_p1  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RECV);

    // Stage p2: FIFO write, occupancy and registered head presentation
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q, head_ptr;
    logic [OW-1:0]      occ_q, occ_d;
    logic               full, pop, wr_ok, drop, head_nz;
    logic [ENTRY_W-1:0] head_word;

    assign full  = (occ_q == OW'(DEPTH));
    assign pop   = rx_valid && rx_ready;
    assign wr_ok = vld_p1 && (!full || pop);
    assign drop  = vld_p1 && full && !pop;

    always_comb begin
        occ_d = occ_q;
        case ({wr_ok, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= {data_p1, sof_p1, eof_p1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(wr_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            occ_q    <= occ_d;
        end
    end

    // The head register looks past an accepted word; a word written this
    // edge becomes visible one edge later, which gives the two-edge latency.
    assign head_ptr  = rd_ptr_q + AW'(pop);
    assign head_nz   = pop ? (occ_q > OW'(1)) : (occ_q != '0);
    assign head_word = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= head_nz;
            rx_sof   <= head_nz && head_word[1];
            rx_eof   <= head_nz && head_word[0];
            if (head_nz) begin
                rx_data <= head_word[ENTRY_W-1:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            frame_err <= ferr_d;
            overflow  <= drop;
            if (drop) begin
                ovf_cnt <= sat_inc8(ovf_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ppi_rx.sv
// Randomized scoreboard bench for ppi_rx with a frame-level reference model.
module tb_ppi_rx;

    localparam int FL = 16;
    localparam int DP = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        ppi_FS = 1'b0;
    logic [15:0] ppi_data = '0;
    logic        rx_ready = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid, rx_sof, rx_eof, frame_err, overflow, busy;
    logic [7:0]  ovf_cnt;

    ppi_rx #(.FRAME_LEN(FL), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .en(en), .ppi_FS(ppi_FS), .ppi_data(ppi_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .frame_err(frame_err),
        .overflow(overflow), .ovf_cnt(ovf_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int   cyc;
        logic ferr;
        logic ovf;
        logic busy;
        int   ovfc;
    } pexp_t;

    logic [17:0] exp_q[$];
    pexp_t       pq[$];

    // Reference model: frame position, FIFO occupancy and drop counter
    logic        m_fs = 1'b0, m_en = 1'b0;
    logic [15:0] m_data = '0;
    bit          in_frame = 0;
    int          pos = 0;
    int          occ = 0;
    int          ovfc = 0;

    initial begin
        forever begin
            bit m_pop, ferr, ovf, wr, wsof, weof;
            @(posedge clk);
            #3;
            m_pop = (rx_valid === 1'b1) && (rx_ready === 1'b1);
            ferr = 0; ovf = 0; wr = 0; wsof = 0; weof = 0;
            if (rst) begin
                in_frame = 0; pos = 0; occ = 0; ovfc = 0;
                m_fs = 1'b0; m_en = 1'b0;
            end else begin
                if (!m_en) begin
                    in_frame = 0; pos = 0;
                end else if (m_fs) begin
                    ferr = in_frame; wr = 1; wsof = 1; in_frame = 1; pos = 1;
                end else if (in_frame) begin
                    wr = 1;
                    weof = (pos == FL - 1);
                    pos++;
                    if (weof) begin in_frame = 0; pos = 0; end
                end
                if (wr) begin
                    if (occ == DP && !m_pop) begin
                        ovf = 1;
                        if (ovfc < 255) ovfc++;
                    end else begin
                        exp_q.push_back({m_data, wsof, weof});
                        occ++;
                    end
                end
                if (m_pop) occ--;
                m_fs = ppi_FS; m_en = en; m_data = ppi_data;
            end
            pq.push_back('{cyc + 1, ferr, ovf, in_frame, ovfc});
        end
    end

    // Monitor: compare delivered words and per-cycle flags
    always @(negedge clk) begin
        logic [17:0] e;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {14'd0, rx_data, rx_sof, rx_eof}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("word", {14'd0, rx_data, rx_sof, rx_eof}, {14'd0, e});
            end
        end else if (rx_valid === 1'b0) begin
            chk("idle_flags", {30'd0, rx_sof, rx_eof}, 32'd0);
        end
        while (pq.size() > 0 && pq[0].cyc < cyc) void'(pq.pop_front());
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            chk("frame_err", 32'(frame_err), 32'(pq[0].ferr));
            chk("overflow", 32'(overflow), 32'(pq[0].ovf));
            chk("busy", 32'(busy), 32'(pq[0].busy));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(pq[0].ovfc));
            void'(pq.pop_front());
        end
        if (rst === 1'b1) exp_q.delete();
    end

    task automatic drive(input logic fs, input logic [15:0] d, input logic e,
                         input logic r, input logic rs);
        @(posedge clk);
        #1;
        ppi_FS = fs; ppi_data = d; en = e; rx_ready = r; rst = rs;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b1, r, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] base, input logic r);
        for (int i = 0; i < FL; i++) drive(i == 0, base + 16'(i), 1'b1, r, 1'b0);
    endtask

    initial begin
        int tx_pos;
        logic fs;
        logic rdy;

        // reset values
        for (int i = 0; i < 4; i++) drive(1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_sof", 32'(rx_sof), 32'd0);
        chk("rst_eof", 32'(rx_eof), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        idle(3, 1'b1);

        // single frame with latency checks
        for (int i = 0; i < FL; i++) begin
            drive(i == 0, 16'h1000 + 16'(i), 1'b1, 1'b1, 1'b0);
            if (i == 2) chk("lat_not_yet", 32'(rx_valid), 32'd0);
            if (i == 3) begin
                chk("lat_valid", 32'(rx_valid), 32'd1);
                chk("lat_data", 32'(rx_data), 32'h1000);
                chk("lat_sof", 32'(rx_sof), 32'd1);
            end
        end
        idle(6, 1'b1);

        // continuous stream: FS every 16 cycles, data = cycle count
        for (int i = 0; i < 4 * FL; i++) drive((i % FL) == 0, 16'(cyc), 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);

        // short frame followed by a new frame
        for (int i = 0; i < 5; i++) drive(i == 0, 16'hA0 + 16'(i), 1'b1, 1'b1, 1'b0);
        send_frame(16'hB0, 1'b1);
        idle(6, 1'b1);

        // backpressure: three frames with no consumer
        for (int f = 0; f < 3; f++) send_frame(16'h2000 + 16'(f * 16), 1'b0);
        idle(3, 1'b0);
        chk("ovf_total", 32'(ovf_cnt), 32'd16);
        chk("full_valid", 32'(rx_valid), 32'd1);

        // full FIFO: consumer resumes exactly as a new word is written
        for (int i = 0; i < FL; i++) begin
            drive(i == 0, 16'hC000 + 16'(i), 1'b1, i != 0, 1'b0);
            if (i == 2) chk("full_pop_no_ovf", 32'(overflow), 32'd0);
        end
        idle(60, 1'b1);

        // reset at word 7 of a frame
        for (int i = 0; i < 8; i++) drive(i == 0, 16'h6000 + 16'(i), 1'b1, 1'b1, i == 7);
        drive(1'b0, 16'h6008, 1'b1, 1'b1, 1'b0);
        chk("rst_mid_valid", 32'(rx_valid), 32'd0);
        for (int i = 9; i < 12; i++) drive(1'b0, 16'h6000 + 16'(i), 1'b1, 1'b1, 1'b0);
        send_frame(16'h7000, 1'b1);
        idle(6, 1'b1);

        // capture disabled at word 3
        for (int i = 0; i < 6; i++) drive(i == 0, 16'h8000 + 16'(i), i != 3, 1'b1, 1'b0);
        chk("en_busy", 32'(busy), 32'd0);
        chk("en_ferr", 32'(frame_err), 32'd0);
        idle(6, 1'b1);

        // randomized traffic
        tx_pos = FL;
        for (int n = 0; n < 1500; n++) begin
            fs = 1'b0;
            if (tx_pos >= FL) fs = ($urandom % 4) != 0;
            else              fs = ($urandom % 40) == 0;
            if (fs) tx_pos = 1;
            else if (tx_pos < FL) tx_pos++;
            if (((n / 64) % 4) == 3) rdy = ($urandom % 8) == 0;
            else                     rdy = ($urandom % 4) != 0;
            drive(fs, 16'($urandom), ($urandom % 60) != 0, rdy, ($urandom % 500) == 0);
        end
        idle(100, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(rx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
